// File: rtl/nes_controller_pkg.sv
// Shared constants for the NES joypad model: button bit positions and shifter reset value.
package nes_controller_pkg;

    localparam int NUM_BTNS  = 8;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [NUM_BTNS-1:0] SHIFTER_RESET = 8'h00;

endpackage

// File: rtl/nes_turbo_gen.sv
// Autofire phase generator: free-running counter, phase toggles every HALF_PERIOD clk cycles.
module nes_turbo_gen #(
    parameter logic [15:0] HALF_PERIOD = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);

    logic [15:0] count_reg;
    logic [15:0] count_next;
    logic        phase_reg;
    logic        phase_next;

    // A HALF_PERIOD of 0 is treated like 1 so the terminal count never underflows.
    localparam logic [15:0] LAST_COUNT = (HALF_PERIOD == 16'd0) ? 16'd0 : HALF_PERIOD - 16'd1;

    always_comb begin
        count_next = count_reg + 16'd1;
        phase_next = phase_reg;
        if (count_reg >= LAST_COUNT) begin
            count_next = 16'd0;
            phase_next = ~phase_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 16'd0;
            phase_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            phase_reg <= phase_next;
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/nes_controller.sv
// Behavioural 4021-style NES joypad: parallel load on strobe, one shift per falling edge of rd.
// Optional autofire masking is enabled by defining NES_CONTROLLER_TURBO_EN.
module nes_controller
    import nes_controller_pkg::*;
#(
    parameter logic [7:0]  TURBO_MASK        = 8'h00,
    parameter logic [15:0] TURBO_HALF_PERIOD = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic       rd,
    input  logic [7:0] btns,
    output logic       data
);

    logic [NUM_BTNS-1:0] shifter_reg;
    logic [NUM_BTNS-1:0] shifter_next;
    logic                rd_q_reg;
    logic [NUM_BTNS-1:0] load_value;

`ifdef NES_CONTROLLER_TURBO_EN
    logic turbo_phase;

    nes_turbo_gen #(
        .HALF_PERIOD (TURBO_HALF_PERIOD)
    ) u_turbo_gen (
        .clk   (clk),
        .rst   (rst),
        .phase (turbo_phase)
    );

    // Masked buttons read as released during the active autofire phase.
    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_turbo_mask
            assign load_value[gi] = btns[gi] & ~(TURBO_MASK[gi] & turbo_phase);
        end
    endgenerate
`else
    logic unused_turbo_params;
    assign unused_turbo_params = ^{TURBO_MASK, TURBO_HALF_PERIOD};
    assign load_value          = btns;
`endif

    // Strobe wins over a read edge; shifting fills with 1 so reads past the eighth return 1.
    always_comb begin
        shifter_next = shifter_reg;
        if (strobe) begin
            shifter_next = load_value;
        end else if (rd_q_reg && !rd) begin
            shifter_next = {1'b1, shifter_reg[NUM_BTNS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter_reg <= SHIFTER_RESET;
            rd_q_reg    <= 1'b0;
        end else begin
            shifter_reg <= shifter_next;
            rd_q_reg    <= rd;
        end
    end

    assign data = shifter_reg[BTN_A];

endmodule

// File: tb/tb_nes_controller.sv
// Self-checking bench for nes_controller against a latched-byte/read-index reference model.
module tb_nes_controller;

    localparam logic [7:0]  TB_MASK = 8'h01;
    localparam logic [15:0] TB_HALF = 16'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] btns = 8'h00;
    logic       data;

    int checks   = 0;
    int failures = 0;

    // Reference model: the byte captured at the last load and how many reads have completed.
    logic [7:0] m_latch = 8'h00;
    int         m_idx   = 0;
    logic       m_rd_prev = 1'b0;
    int         m_cyc   = 0;

    nes_controller #(
        .TURBO_MASK        (TB_MASK),
        .TURBO_HALF_PERIOD (TB_HALF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .rd     (rd),
        .btns   (btns),
        .data   (data)
    );

    always #5 clk = ~clk;

    function automatic logic model_data();
        return (m_idx < 8) ? m_latch[m_idx] : 1'b1;
    endfunction

    // Advance the model by one clock using the inputs now applied, then step past the edge.
    task automatic tick();
        logic [7:0] eff;
        int phase;
        phase = (m_cyc / int'(TB_HALF)) % 2;
        eff = btns;
`ifdef NES_CONTROLLER_TURBO_EN
        if (phase == 1) eff = btns & ~TB_MASK;
`endif
        if (rst) begin
            m_latch   = 8'h00;
            m_idx     = 0;
            m_rd_prev = 1'b0;
            m_cyc     = 0;
        end else begin
            if (strobe) begin
                m_latch = eff;
                m_idx   = 0;
            end else if (m_rd_prev && !rd) begin
                m_idx++;
            end
            m_rd_prev = rd;
            m_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    // One read of the given high width; returns the bit seen while rd is high.
    task automatic do_read(input int width, output logic seen, output logic expect_bit);
        rd = 1'b1;
        tick();
        seen = data;
        expect_bit = model_data();
        for (int i = 1; i < width; i++) tick();
        rd = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic seen, exp_b, plan;
        rst = 1'b1; tick(); tick();
        checks++;
        if (data !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got=%b want=0", data);
        end
        rst = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            do_read(1, seen, exp_b);
            plan = (i < 8) ? 1'b0 : 1'b1;
            checks++;
            if (seen !== exp_b || seen !== plan) begin
                failures++;
                $display("FAIL reset_read%0d got=%b want=%b", i, seen, plan);
            end
            $display("reset read %0d data=%b", i, seen);
        end
    endtask

    task automatic test_load_shift();
        logic seen, exp_b;
        logic [9:0] plan;
        plan = 10'b11_0000_0100;
        btns = 8'b0000_0100;
        strobe = 1'b1; tick(); tick(); tick();
        strobe = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            do_read(2, seen, exp_b);
            checks++;
            if (seen !== exp_b || seen !== plan[i]) begin
                failures++;
                $display("FAIL load_shift_read%0d got=%b want=%b", i, seen, plan[i]);
            end
            $display("load_shift read %0d data=%b", i, seen);
        end
    endtask

    task automatic test_strobe_priority();
        btns = 8'h81;
        strobe = 1'b1; tick();
        for (int p = 0; p < 4; p++) begin
            rd = 1'b1; tick();
            rd = 1'b0; tick();
            checks++;
            if (data !== model_data() || data !== 1'b1) begin
                failures++;
                $display("FAIL strobe_priority_pulse%0d got=%b want=1", p, data);
            end
        end
        btns = 8'h80; tick();
        checks++;
        if (data !== model_data() || data !== 1'b0) begin
            failures++;
            $display("FAIL strobe_reload got=%b want=0", data);
        end
        $display("strobe priority done data=%b", data);
        strobe = 1'b0; tick();
    endtask

    task automatic test_old_latch();
        logic seen, exp_b;
        logic [7:0] plan;
        plan = 8'h55;
        btns = 8'h55;
        strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        btns = 8'hAA; tick();
        for (int i = 0; i < 8; i++) begin
            do_read(1 + (i % 3), seen, exp_b);
            checks++;
            if (seen !== exp_b || seen !== plan[i]) begin
                failures++;
                $display("FAIL old_latch_read%0d got=%b want=%b", i, seen, plan[i]);
            end
            $display("old_latch read %0d data=%b", i, seen);
        end
    endtask

    task automatic test_reset_mid_read();
        logic seen, exp_b, plan;
        btns = 8'hFF;
        strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        for (int i = 0; i < 3; i++) do_read(1, seen, exp_b);
        rst = 1'b1; tick();
        rst = 1'b0;
        checks++;
        if (data !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_read got=%b want=0", data);
        end
        for (int i = 0; i < 9; i++) begin
            do_read(1, seen, exp_b);
            plan = (i < 8) ? 1'b0 : 1'b1;
            checks++;
            if (seen !== exp_b || seen !== plan) begin
                failures++;
                $display("FAIL post_reset_read%0d got=%b want=%b", i, seen, plan);
            end
        end
        // rd held high across reset must still shift exactly once when it drops.
        btns = 8'h02;
        strobe = 1'b1; tick();
        strobe = 1'b0; rd = 1'b1; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        btns = 8'h00;
        strobe = 1'b1; tick();
        btns = 8'hFE;
        strobe = 1'b1; tick();
        strobe = 1'b0; tick(); tick();
        rd = 1'b0; tick();
        checks++;
        if (data !== model_data() || data !== 1'b1) begin
            failures++;
            $display("FAIL rd_across_reset got=%b want=1", data);
        end
        $display("reset mid read done data=%b", data);
    endtask

    task automatic test_turbo();
        btns = 8'h01;
        strobe = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if (data !== model_data()) begin
                failures++;
                $display("FAIL turbo_cycle%0d got=%b want=%b", c, data, model_data());
            end
        end
`ifndef NES_CONTROLLER_TURBO_EN
        checks++;
        if (data !== 1'b1) begin
            failures++;
            $display("FAIL turbo_disabled got=%b want=1", data);
        end
`endif
        $display("turbo window done data=%b", data);
        strobe = 1'b0; tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            strobe = ($urandom_range(0, 9) == 0);
            rd     = $urandom_range(0, 1);
            btns   = 8'($urandom);
            tick();
            checks++;
            if (data !== model_data()) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d got=%b want=%b", c, data, model_data());
            end
        end
        strobe = 1'b0; rd = 1'b0; tick();
        $display("random stimulus done mismatches=%0d", bad);
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_strobe_priority();
        test_old_latch();
        test_reset_mid_read();
        test_turbo();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
